// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int DIV_W_DEFAULT = 8;

  // Divisors below 2 cannot produce both a high and a low phase.
  function automatic int unsigned clampDiv(input int unsigned div);
    return (div < 2) ? 2 : div;
  endfunction

  function automatic int chanIdxWidth(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: counter, active/shadow config and registered outputs.
module divider_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV  = 2,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             wr_strobe,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] high,
  output logic             new_clock,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] high_act_q, high_act_d;
  logic [DIV_W-1:0] shadow_div_q, shadow_div_d;
  logic [DIV_W-1:0] shadow_high_q, shadow_high_d;
  logic             pending_q, pending_d;
  logic             run_q, run_d;
  logic             new_clock_q, new_clock_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] last_old, last_new;
  logic             boundary;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    shadow_div_d  = shadow_div_q;
    shadow_high_d = shadow_high_q;
    pending_d     = pending_q;
    div_act_d     = div_act_q;
    high_act_d    = high_act_q;
    cnt_d         = '0;
    new_clock_d   = 1'b0;
    tick_d        = 1'b0;
    run_d         = enable;

    if (wr_strobe) begin
      shadow_div_d  = div;
      shadow_high_d = high;
      pending_d     = 1'b1;
    end

    // A period boundary is a wrap, a sync, a (re)start or an idle channel.
    last_old = DIV_W'(clampDiv(32'(div_act_q)) - 1);
    boundary = !enable || sync || !run_q || (cnt_q == last_old);

    if (boundary) begin
      div_act_d  = shadow_div_d;
      high_act_d = shadow_high_d;
      pending_d  = 1'b0;
    end

    last_new = DIV_W'(clampDiv(32'(div_act_d)) - 1);
    if (enable) begin
      cnt_d       = boundary ? '0 : cnt_q + DIV_W'(1);
      new_clock_d = (cnt_d < high_act_d);
      tick_d      = (cnt_d == last_new);
    end
  end

  // NOTE: reset is synchronous, so it is sampled inside the clocked block and
  // clears every register including the shadow copy; state uses <= only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      div_act_q     <= DIV_W'(DEFAULT_DIV);
      high_act_q    <= DIV_W'(DEFAULT_HIGH);
      shadow_div_q  <= DIV_W'(DEFAULT_DIV);
      shadow_high_q <= DIV_W'(DEFAULT_HIGH);
      pending_q     <= 1'b0;
      run_q         <= 1'b0;
      new_clock_q   <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      div_act_q     <= div_act_d;
      high_act_q    <= high_act_d;
      shadow_div_q  <= shadow_div_d;
      shadow_high_q <= shadow_high_d;
      pending_q     <= pending_d;
      run_q         <= run_d;
      new_clock_q   <= new_clock_d;
      tick_q        <= tick_d;
    end
  end

  assign new_clock = new_clock_q;
  assign tick      = tick_q;
  assign pending   = pending_q;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable divider: channel array plus config write decode.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH       = 4,
  parameter int  DIV_W        = DIV_W_DEFAULT,
  parameter int  DEFAULT_DIV  = 2,
  parameter int  DEFAULT_HIGH = 1,
  localparam int CH_W         = chanIdxWidth(NUM_CH)
) (
  input  logic              sysClock,
  input  logic              sysReset_n,
  input  logic [NUM_CH-1:0] chEnable,
  input  logic              syncAll,
  input  logic              cfgWrite,
  input  logic [CH_W-1:0]   cfgChan,
  input  logic [DIV_W-1:0]  cfgDiv,
  input  logic [DIV_W-1:0]  cfgHigh,
  output logic [NUM_CH-1:0] newClock,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfgPending
);

  logic [NUM_CH-1:0] wr_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no channel and are dropped.
    assign wr_sel[i] = cfgWrite && (int'(cfgChan) == i);

    divider_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_channel (
      .clk      (sysClock),
      .rst_n    (sysReset_n),
      .enable   (chEnable[i]),
      .sync     (syncAll),
      .wr_strobe(wr_sel[i]),
      .div      (cfgDiv),
      .high     (cfgHigh),
      .new_clock(newClock[i]),
      .tick     (tick[i]),
      .pending  (cfgPending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench: a behavioural model predicts each edge, plus fixed-pattern checks.
module tb_multi_clock_divider;

  localparam int NC = 3;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] en;
  logic          sync_all;
  logic          cfg_write;
  logic [1:0]    cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_high;
  logic [NC-1:0] new_clock;
  logic [NC-1:0] tick;
  logic [NC-1:0] cfg_pending;

  multi_clock_divider #(
    .NUM_CH      (NC),
    .DIV_W       (DW),
    .DEFAULT_DIV (2),
    .DEFAULT_HIGH(1)
  ) dut (
    .sysClock  (clk),
    .sysReset_n(rst_n),
    .chEnable  (en),
    .syncAll   (sync_all),
    .cfgWrite  (cfg_write),
    .cfgChan   (cfg_chan),
    .cfgDiv    (cfg_div),
    .cfgHigh   (cfg_high),
    .newClock  (new_clock),
    .tick      (tick),
    .cfgPending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [NC-1:0] nc;
    logic [NC-1:0] tk;
    logic [NC-1:0] pd;
  } exp_t;

  exp_t sb_q[$];

  int            m_cnt[NC], m_div[NC], m_high[NC], m_sdiv[NC], m_shigh[NC];
  bit            m_pend[NC], m_run[NC];
  logic [NC-1:0] m_nc, m_tk;

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    exp_t e;
    for (int ch = 0; ch < NC; ch++) begin
      if (!rst_n) begin
        m_cnt[ch] = 0; m_div[ch] = 2; m_high[ch] = 1;
        m_sdiv[ch] = 2; m_shigh[ch] = 1;
        m_pend[ch] = 0; m_run[ch] = 0; m_nc[ch] = 0; m_tk[ch] = 0;
      end else begin
        if (cfg_write && int'(cfg_chan) == ch) begin
          m_sdiv[ch] = int'(cfg_div); m_shigh[ch] = int'(cfg_high); m_pend[ch] = 1;
        end
        if (!en[ch]) begin
          m_div[ch] = m_sdiv[ch]; m_high[ch] = m_shigh[ch]; m_pend[ch] = 0;
          m_cnt[ch] = 0; m_nc[ch] = 0; m_tk[ch] = 0; m_run[ch] = 0;
        end else begin
          if (sync_all || !m_run[ch] || m_cnt[ch] == eff_div(m_div[ch]) - 1) begin
            m_div[ch] = m_sdiv[ch]; m_high[ch] = m_shigh[ch]; m_pend[ch] = 0;
            m_cnt[ch] = 0;
          end else begin
            m_cnt[ch]++;
          end
          m_nc[ch] = (m_cnt[ch] < m_high[ch]);
          m_tk[ch] = (m_cnt[ch] == eff_div(m_div[ch]) - 1);
          m_run[ch] = 1;
        end
      end
    end
    for (int ch = 0; ch < NC; ch++) e.pd[ch] = m_pend[ch];
    e.nc = m_nc;
    e.tk = m_tk;
    sb_q.push_back(e);
  endtask

  // One clock: predict, advance, sample 1 time unit after the edge, compare.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("newClock", new_clock, e.nc);
      check("tick", tick, e.tk);
      check("cfgPending", cfg_pending, e.pd);
    end
    cfg_write = 1'b0;
    sync_all  = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input int d, input int h);
    cfg_write = 1'b1;
    cfg_chan  = 2'(ch);
    cfg_div   = DW'(d);
    cfg_high  = DW'(h);
    step();
  endtask

  task automatic capture(input int ch, input int n,
                         output logic [31:0] nc_seq, output logic [31:0] tk_seq);
    nc_seq = '0;
    tk_seq = '0;
    for (int i = 0; i < n; i++) begin
      step();
      nc_seq = {nc_seq[30:0], new_clock[ch]};
      tk_seq = {tk_seq[30:0], tick[ch]};
    end
  endtask

  logic [31:0] nc_seq, tk_seq, both_seq;
  int          guard;

  initial begin
    rst_n = 1'b0; en = '0; sync_all = 1'b0; cfg_write = 1'b0;
    cfg_chan = '0; cfg_div = '0; cfg_high = '0;

    step(); step();
    check("rst_newClock", new_clock, 0);
    check("rst_tick", tick, 0);
    check("rst_pending", cfg_pending, 0);
    rst_n = 1'b1;
    step();

    // Defaults on ch0: D=2, H=1.
    en[0] = 1'b1;
    capture(0, 4, nc_seq, tk_seq);
    check("def_nc", nc_seq, 32'b1010);
    check("def_tk", tk_seq, 32'b0101);

    // ch1 to D=4 H=2 while running; pending until first wrap.
    en[1] = 1'b1;
    step();
    write_cfg(1, 4, 2);
    check("d4_pend_set", cfg_pending[1], 1);
    capture(1, 8, nc_seq, tk_seq);
    check("d4_nc", nc_seq, 32'b11001100);
    check("d4_tk", tk_seq, 32'b00010001);
    check("d4_pend_clr", cfg_pending[1], 0);

    write_cfg(3, 9, 9);
    check("bad_chan", cfg_pending, 0);

    // Mid-period rewrite at cnt=1: old period finishes, then 111000.
    step();
    write_cfg(1, 6, 3);
    capture(1, 13, nc_seq, tk_seq);
    check("rewrite_nc", nc_seq, 32'b0_111000_111000);
    check("rewrite_tk", tk_seq, 32'b1_000001_000001);

    // Boundaries on ch2, configured while idle so they apply immediately.
    write_cfg(2, 0, 1);
    check("idle_apply", cfg_pending[2], 0);
    en[2] = 1'b1;
    capture(2, 4, nc_seq, tk_seq);
    check("div0_nc", nc_seq, 32'b1010);
    check("div0_tk", tk_seq, 32'b0101);
    en[2] = 1'b0;
    write_cfg(2, 3, 0);
    en[2] = 1'b1;
    capture(2, 6, nc_seq, tk_seq);
    check("high0_nc", nc_seq, 32'b000000);
    check("high0_tk", tk_seq, 32'b001001);
    en[2] = 1'b0;
    write_cfg(2, 5, 9);
    en[2] = 1'b1;
    capture(2, 10, nc_seq, tk_seq);
    check("highbig_nc", nc_seq, 32'h3FF);
    check("highbig_tk", tk_seq, 32'b0000100001);

    // Phase alignment of D=3 and D=5 via syncAll.
    en[1:0] = 2'b00;
    write_cfg(0, 3, 1);
    write_cfg(1, 5, 2);
    en[0] = 1'b1;
    step(); step();
    en[1] = 1'b1;
    step(); step();
    sync_all = 1'b1;
    step();
    check("sync_nc", new_clock[1:0], 2'b11);
    check("sync_tk", tick[1:0], 2'b00);
    both_seq = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      both_seq = {both_seq[30:0], tick[0] & tick[1]};
    end
    check("sync_coincide", both_seq, 32'b00000000000001);

    // Reset with a write pending at cnt=3.
    guard = 0;
    while (m_cnt[1] != 0 && guard < 10) begin
      step();
      guard++;
    end
    check("wait_cnt0", m_cnt[1], 0);
    write_cfg(1, 7, 3);
    step(); step();
    check("pre_rst_pend", cfg_pending[1], 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_nc", new_clock, 0);
    check("mid_rst_tk", tick, 0);
    check("mid_rst_pend", cfg_pending, 0);
    rst_n = 1'b1;
    capture(1, 4, nc_seq, tk_seq);
    check("post_rst_nc", nc_seq, 32'b1010);

    // ch0 is at cnt=1: a write on the wrap edge applies at that edge.
    write_cfg(0, 4, 2);
    check("wrap_same", cfg_pending[0], 0);
    write_cfg(0, 6, 1);
    check("dis_pend_set", cfg_pending[0], 1);
    en[0] = 1'b0;
    step();
    check("dis_nc", new_clock[0], 0);
    check("dis_pend_clr", cfg_pending[0], 0);
    en[0] = 1'b1;
    capture(0, 6, nc_seq, tk_seq);
    check("reen_nc", nc_seq, 32'b100000);
    check("reen_tk", tk_seq, 32'b000001);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      en        = NC'($urandom);
      sync_all  = ($urandom_range(0, 15) == 0);
      cfg_write = ($urandom_range(0, 3) == 0);
      cfg_chan  = 2'($urandom_range(0, 3));
      cfg_div   = DW'($urandom_range(0, 7));
      cfg_high  = DW'($urandom_range(0, 8));
      if ($urandom_range(0, 7) != 0) en = '1;
      step();
    end

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Multi-channel programmable clock-enable/divided-clock generator.
- Each channel has a runtime divisor and high-time (duty).
- Config writes are shadowed and take effect only on a period boundary, so the output never glitches.
- Sits beside the system clock tree and feeds VGA pixel timing, UART baud ticks and slow peripheral strobes from one sysClock domain.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- DIV_W, 8: width of the divisor and high-time fields. Counter width equals DIV_W.
- DEFAULT_DIV, 2: divisor loaded into every channel at reset (>=2).
- DEFAULT_HIGH, 1: high-time loaded into every channel at reset.

Ports:
- sysClock  in  1  system clock; all logic rises on posedge.
- sysReset_n  in  1  synchronous active-low reset.
- chEnable  in  NUM_CH  per-channel run enable.
- syncAll  in  1  single-cycle pulse; phase-aligns all enabled channels.
- cfgWrite  in  1  config write strobe.
- cfgChan  in  clog2(NUM_CH) (min 1)  target channel of the write.
- cfgDiv  in  DIV_W  new divisor.
- cfgHigh  in  DIV_W  new high-time, in cycles.
- newClock  out  NUM_CH  divided clock per channel (registered).
- tick  out  NUM_CH  one-cycle pulse on the last cycle of each period (registered).
- cfgPending  out  NUM_CH  shadow config waiting to be applied.

Behaviour:
- Interface: one clock, sysClock. Reset sysReset_n is synchronous and active-low.
- Reset (sysReset_n=0 at a posedge), per channel:
  - cnt=0, divAct=DEFAULT_DIV, highAct=DEFAULT_HIGH
  - shadow=active, cfgPending=0, newClock=0, tick=0
  - Reset dominates every other input.
- Effective divisor: D = max(divAct, 2). Values 0 and 1 are clamped to 2. Clamping applies at use; the stored value is unchanged.
- Enabled channel, each posedge:
  - cntNext = (cnt==D-1) ? 0 : cnt+1
  - newClock <= (cntNext < highAct)
  - tick <= (cntNext == D-1)
  - newClock and tick are coherent with the registered cnt.
- Duty: highAct=0 gives constant 0. highAct>=D gives constant 1. tick keeps pulsing in both cases.
- Disabled channel (chEnable=0): cnt<=0, newClock<=0, tick<=0. Any pending shadow is applied immediately.
- On re-enable, the first enabled posedge gives cnt=0 and newClock=(0<highAct). A full period follows.
- Config write: cfgWrite=1 latches cfgDiv/cfgHigh into shadow[cfgChan] and sets cfgPending.
  - Last write before application wins.
  - cfgChan>=NUM_CH: write ignored.
- Application: shadow is copied to divAct/highAct and cfgPending cleared when the channel wraps (cnt==D-1 this cycle), so the next period (cnt=0) uses the new values.
  - A write in the same cycle as a wrap is applied at that wrap.
- syncAll=1 forces cnt<=0 on every enabled channel; outputs are computed with cntNext=0.
  - Pending shadows are applied at the same edge, including a same-cycle cfgWrite.
  - syncAll takes priority over normal wrap.
- Reset mid-period: outputs are 0 the next cycle and pending writes are lost.
- Latency: a write applies at most D_old cycles later. tick period = D. newClock high for min(highAct,D) cycles per period.

Decomposition:
- Package clkdiv_pkg:
  - DIV_W default
  - function clampDiv(div) returning max(div,2)
  - function chanIdxWidth(NUM_CH)
- Sub-module divider_channel:
  - holds cnt, active and shadow registers, newClock/tick flops for one channel
  - ports: clk, reset, enable, sync, wrStrobe, div, high, newClock, tick, pending
- Top: generate loop over NUM_CH plus cfgChan decode.

Test Plan:
- Reset then enable ch0 with defaults (D=2, H=1): newClock 1,0,1,0…; tick on every cycle where newClock=0.
- Write ch1 div=4 high=2: newClock=1100 repeating. tick on the 4th cycle of each period. cfgPending high exactly until the first wrap.
- Mid-period rewrite: ch1 running D=4, write div=6 high=3 at cnt=1. The current period finishes at 4 cycles, then 111000 repeats.
- Boundaries: div=0 behaves as D=2. high=0 gives newClock constant 0 with tick every D. high=9, div=5 gives constant 1.
- Phase alignment: ch0 D=3, ch1 D=5, both enabled, pulse syncAll. Next cycle both cnt=0. Ticks coincide again 15 cycles later.
- Reset/disable mid-operation:
  - Assert sysReset_n=0 during cnt=3 with a write pending: next cycle all outputs 0, div back to DEFAULT.
  - Drop chEnable with pending config: newClock=0, cfgPending clears next cycle.
